// File: rtl/soc_irq_pkg.sv
// ============================================================================
//  soc_irq_pkg : register map, widths and priority encoder for soc_irq_ctrl
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package soc_irq_pkg;

  localparam int IRQ_MAX_SRC = 16;
  localparam int IRQ_DATA_W  = 16;

  localparam logic [2:0] IRQ_ADDR_RAW      = 3'd0;
  localparam logic [2:0] IRQ_ADDR_PENDING  = 3'd1;
  localparam logic [2:0] IRQ_ADDR_MASK     = 3'd2;
  localparam logic [2:0] IRQ_ADDR_EDGE_SEL = 3'd3;
  localparam logic [2:0] IRQ_ADDR_ACTIVE   = 3'd4;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] irq_prio_enc(input logic [IRQ_DATA_W-1:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = IRQ_DATA_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/soc_irq_sync.sv
// ============================================================================
//  soc_irq_sync : parameterized-width 2-flop synchronizer, sync active-low reset
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module soc_irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/soc_irq_ctrl.sv
// ============================================================================
//  soc_irq_ctrl : Avalon-MM interrupt controller, up to 16 level/edge sources.
//  Optional input synchronizer enabled by defining SOC_IRQ_CTRL_SYNC_EN.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module soc_irq_ctrl
  import soc_irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [IRQ_DATA_W-1:0] writedata,
  output logic [IRQ_DATA_W-1:0] readdata,
  input  logic [NUM_SRC-1:0]    irq_in,
  output logic                  irq_out
);

  // State is kept at full register width; bits at or above NUM_SRC are forced to 0.
  localparam logic [IRQ_DATA_W-1:0] SRC_VLD = IRQ_DATA_W'((32'h1 << NUM_SRC) - 1);

  logic [NUM_SRC-1:0]    s_src;
  logic [IRQ_DATA_W-1:0] s;
  logic [IRQ_DATA_W-1:0] p;
  logic [IRQ_DATA_W-1:0] pending;
  logic [IRQ_DATA_W-1:0] mask;
  logic [IRQ_DATA_W-1:0] edge_sel;
  logic [IRQ_DATA_W-1:0] edge_det;
  logic [IRQ_DATA_W-1:0] w1c;
  logic [IRQ_DATA_W-1:0] pending_nxt;
  logic [IRQ_DATA_W-1:0] active_vec;
  logic [IRQ_DATA_W-1:0] rd_mux;
  logic                  wr;

`ifdef SOC_IRQ_CTRL_SYNC_EN
  soc_irq_sync #(
    .WIDTH (NUM_SRC)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (irq_in),
    .q       (s_src)
  );
`else
  assign s_src = irq_in;
`endif

  always_comb begin
    s                = '0;
    s[NUM_SRC-1:0]   = s_src;
  end

  assign wr         = chipselect && !write_n;
  assign w1c        = (wr && address == IRQ_ADDR_PENDING) ? writedata : '0;
  assign edge_det   = s & ~p;
  assign active_vec = pending & mask;

  // Edge sources: a new edge beats a same-cycle clear. Level sources track s.
  assign pending_nxt = ((edge_sel & (edge_det | (pending & ~w1c))) |
                        (~edge_sel & s)) & SRC_VLD;

  always_comb begin
    rd_mux = '0;
    case (address)
      IRQ_ADDR_RAW:      rd_mux = s;
      IRQ_ADDR_PENDING:  rd_mux = pending;
      IRQ_ADDR_MASK:     rd_mux = mask;
      IRQ_ADDR_EDGE_SEL: rd_mux = edge_sel;
      IRQ_ADDR_ACTIVE:   rd_mux = {|active_vec, 11'd0, irq_prio_enc(active_vec)};
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p        <= '0;
      pending  <= '0;
      mask     <= '0;
      edge_sel <= '0;
      readdata <= '0;
      irq_out  <= 1'b0;
    end else begin
      p        <= s;
      pending  <= pending_nxt;
      readdata <= rd_mux;
      irq_out  <= |active_vec;
      if (wr && address == IRQ_ADDR_MASK)     mask     <= writedata & SRC_VLD;
      if (wr && address == IRQ_ADDR_EDGE_SEL) edge_sel <= writedata & SRC_VLD;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_soc_irq_ctrl.sv
// ============================================================================
//  tb_soc_irq_ctrl : scoreboard bench for soc_irq_ctrl (directed vectors)
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_soc_irq_ctrl;

`ifdef SOC_IRQ_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam logic [2:0] A_RAW = 3'd0;
  localparam logic [2:0] A_PEND = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_ACT = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq_out;

  soc_irq_ctrl #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } item_t;

  item_t rd_q[$];
  item_t irq_q[$];
  int    total = 0;
  int    bad   = 0;
  logic  chk_irq = 1'b0;
  logic  rd_v    = 1'b0;
  logic  irq_v   = 1'b0;

  always @(posedge clk) begin
    rd_v  <= chipselect && write_n;
    irq_v <= chk_irq;
  end

  // Monitor: pops expectations whenever a read result or irq sample is due.
  always @(negedge clk) begin
    item_t it;
    if (rd_v) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_underflow: readdata=%04h with no expectation", readdata);
      end else begin
        it = rd_q.pop_front();
        if (readdata !== it.exp) begin
          bad++;
          $display("FAIL %s: readdata got %04h want %04h", it.name, readdata, it.exp);
        end
      end
    end
    if (irq_v) begin
      total++;
      if (irq_q.size() == 0) begin
        bad++;
        $display("FAIL irq_underflow: irq_out=%0b with no expectation", irq_out);
      end else begin
        it = irq_q.pop_front();
        if (irq_out !== it.exp[0]) begin
          bad++;
          $display("FAIL %s: irq_out got %0b want %0b", it.name, irq_out, it.exp[0]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    chk_irq    = 1'b0;
  endtask

  task automatic settle();
    repeat (SYNC_LAT) tick();
  endtask

  task automatic do_wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
  endtask

  task automatic exp_rd(input string n, input logic [2:0] a, input logic [15:0] e);
    item_t it;
    it.name = n;
    it.exp  = e;
    rd_q.push_back(it);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
  endtask

  task automatic exp_irq(input string n, input logic e);
    item_t it;
    it.name = n;
    it.exp  = {15'd0, e};
    irq_q.push_back(it);
    chk_irq = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    irq_in     = '0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset state: every register reads zero, no interrupt.
    for (int a = 0; a < 8; a++) begin
      exp_rd("reset_rd", 3'(a), 16'h0000);
      if (a == 0) exp_irq("reset_irq", 1'b0);
      tick();
    end

    // Edge source 0: single-cycle pulse, latency check.
    do_wr(A_MASK, 16'h0001); tick();
    do_wr(A_EDGE, 16'h0001); tick();
    irq_in[0] = 1'b1;
    exp_irq("pulse_irq_edge_k", 1'b0);
    tick();
    irq_in[0] = 1'b0;
    for (int i = 0; i < SYNC_LAT; i++) begin
      exp_irq("pulse_irq_sync_wait", 1'b0);
      tick();
    end
    exp_irq("pulse_irq_edge_k1", 1'b1); tick();
    exp_rd("pulse_pending", A_PEND, 16'h0001); tick();
    exp_rd("pulse_active", A_ACT, 16'h8000); tick();

    // W1C colliding with a new edge: set wins.
    irq_in[0] = 1'b1;
    settle();
    do_wr(A_PEND, 16'h0001); tick();
    exp_rd("w1c_collide_pending", A_PEND, 16'h0001);
    exp_irq("w1c_collide_irq", 1'b1);
    tick();
    do_wr(A_PEND, 16'h0001); tick();
    irq_in[0] = 1'b0;
    exp_rd("w1c_idle_pending", A_PEND, 16'h0000);
    exp_irq("w1c_idle_irq", 1'b0);
    tick();

    // Level source 3 and edge source 5.
    do_wr(A_EDGE, 16'h0020); tick();
    do_wr(A_MASK, 16'h0028); tick();
    irq_in[3] = 1'b1;
    irq_in[5] = 1'b1;
    tick(); settle(); tick();
    exp_rd("prio_active_3", A_ACT, 16'h8003); tick();
    irq_in[3] = 1'b0;
    tick(); settle();
    exp_rd("prio_active_5", A_ACT, 16'h8005); tick();
    do_wr(A_PEND, 16'h0020); tick();
    exp_rd("prio_active_none", A_ACT, 16'h0000);
    exp_irq("prio_irq_none", 1'b0);
    tick();
    irq_in[5] = 1'b0;

    // All inputs high with everything masked.
    do_wr(A_MASK, 16'h0000); tick();
    do_wr(A_EDGE, 16'h0000); tick();
    irq_in = 8'hFF;
    tick(); settle(); tick();
    exp_rd("masked_pending", A_PEND, 16'h00FF);
    exp_irq("masked_irq", 1'b0);
    tick();
    exp_rd("masked_raw", A_RAW, 16'h00FF); tick();
    do_wr(A_MASK, 16'h00FF);
    exp_irq("unmask_irq_same_edge", 1'b0);
    tick();
    exp_irq("unmask_irq_next_edge", 1'b1); tick();
    do_wr(A_MASK, 16'hFFFF); tick();
    exp_rd("mask_upper_bits", A_MASK, 16'h00FF); tick();
    exp_rd("all_active", A_ACT, 16'h8000); tick();
    do_wr(3'd5, 16'hFFFF); tick();
    exp_rd("unused_addr", 3'd5, 16'h0000); tick();

    // Reset while irq_out is high and edge source 0 held high.
    do_wr(A_EDGE, 16'h0001); tick();
    irq_in = 8'h01;
    tick(); settle(); tick();
    exp_irq("pre_reset_irq", 1'b1); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_irq("reset_irq_cleared", 1'b0);
    tick(); settle(); tick();
    exp_rd("post_reset_pending", A_PEND, 16'h0001);
    exp_irq("post_reset_irq", 1'b0);
    tick();
    exp_rd("post_reset_mask", A_MASK, 16'h0000); tick();
    exp_rd("post_reset_edge", A_EDGE, 16'h0000); tick();
    do_wr(A_MASK, 16'h0001);
    exp_irq("remask_irq_same_edge", 1'b0);
    tick();
    exp_irq("remask_irq_next_edge", 1'b1); tick();

    tick(); tick();
    total++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: rd_left=%0d irq_left=%0d want 0", rd_q.size(), irq_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/soc_irq_ctrl.md
# soc_irq_ctrl

Avalon-MM interrupt controller that sits directly downstream of the interval timer and the other peripheral interrupt sources. It merges up to 16 per-source `irq` lines into one CPU interrupt. Each source has a level or rising-edge latch mode, a mask bit and a pending bit; software reads a priority-encoded active index. The register interface uses the same 16-bit halfword slave protocol as the timer: `address`/`chipselect`/`write_n`, with `readdata` registered every cycle.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..16.
- `clk` input 1: single clock for the whole block.
- `reset_n` input 1: reset, synchronous and active-low.
- `address` input 3: register halfword index.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata` input 16: write data.
- `readdata` output 16: registered read data.
- `irq_in` input NUM_SRC: source interrupt lines, active-high; bit 0 is the timer's `irq`.
- `irq_out` output 1: combined interrupt to the CPU, registered.

## Operation
- Register map (bits at or above NUM_SRC read 0 and ignore writes):
  - 0 RAW (RO): sampled input vector `s`.
  - 1 PENDING: read returns pending bits; write-1-to-clear.
  - 2 MASK (RW): 1 = enabled.
  - 3 EDGE_SEL (RW): 1 = rising-edge latched, 0 = level.
  - 4 ACTIVE (RO): bit15 = any (pending & mask); bits3:0 = lowest set index of (pending & mask), 0 when none.
  - 5..7: read 0, writes ignored.
- `s` is `irq_in`, or the synchronizer output when sync is configured. `p` is `s` delayed one cycle; `edge = s & ~p`.
- Level source: `pending[i] <= s[i]` every cycle. W1C has no effect.
- Edge source: `pending[i]` sets on `edge[i]`. It clears on a W1C with `writedata[i]=1`. If set and clear occur in the same cycle, set wins.
- Changing EDGE_SEL from 1 to 0 makes pending follow `s` from the next edge. Changing it from 0 to 1 keeps the current pending value until it is cleared.
- `irq_out <= |(pending & mask)`. Priority is fixed, lowest index highest.
- `readdata <= mux(address)` every cycle, regardless of `chipselect`. Reads have no side effects.
- Reset values: `readdata`, `irq_out`, `pending`, MASK, EDGE_SEL, `p` and the sync flops all reset to 0.
- Because `p` resets to 0, an edge source held high through reset latches once on the first cycle after reset release.

## Timing
- A write takes effect at the clock edge where `chipselect && !write_n`.
- Read latency is one cycle: `readdata` reflects the `address` presented on the previous edge.
- Input to pending, no sync: `irq_in` high at edge k makes pending visible after edge k. `irq_out` rises after edge k+1.
- With sync, both of those points move 2 cycles later.
- Mask write at edge k: `irq_out` responds after edge k+1.
- W1C at edge k clears pending after edge k. `irq_out` falls after edge k+1.
- A W1C coinciding with a new edge leaves pending at 1.
- `reset_n` low at any edge clears all state at that edge, including mid-operation. `irq_out` is 0 from the following cycle.

## Configuration
- `SOC_IRQ_CTRL_SYNC_EN` defined: each `irq_in` bit passes through a 2-flop synchronizer before `s`. Input-to-`irq_out` latency is 4 edges.
- `SOC_IRQ_CTRL_SYNC_EN` undefined: `s = irq_in` directly, for sources already in the `clk` domain. Latency is 2 edges.
- The register map is identical in both builds.

## Structure
- Package `soc_irq_pkg`:
  - register address constants `IRQ_ADDR_RAW` .. `IRQ_ADDR_ACTIVE`;
  - `IRQ_MAX_SRC = 16`;
  - `IRQ_DATA_W = 16`.
- Sub-module `soc_irq_sync`:
  - parameterized-width 2-flop synchronizer;
  - synchronous active-low reset to 0;
  - instantiated only under `SOC_IRQ_CTRL_SYNC_EN`.
- The priority encoder is a function in `soc_irq_pkg`.

## Test plan
- Reset then read all addresses: every read returns 0x0000; `irq_out` = 0.
- Write MASK=0x0001 and EDGE_SEL=0x0001, then pulse `irq_in[0]` for 1 cycle:
  - PENDING = 0x0001; ACTIVE = 0x8000;
  - `irq_out` high 2 edges after the pulse without sync, 4 with sync.
- Write PENDING=0x0001 in the same cycle as a new edge on `irq_in[0]`: PENDING stays 0x0001 and `irq_out` stays 1. A W1C on the next idle cycle clears both.
- Level source 3 and edge source 5 both pending, MASK=0x0028:
  - ACTIVE = 0x8003;
  - drop `irq_in[3]` -> ACTIVE = 0x8005;
  - W1C 0x0020 -> ACTIVE = 0x0000 and `irq_out` = 0.
- MASK=0x0000 with all inputs high: PENDING shows the bits but `irq_out` stays 0. Writing MASK=0x00FF raises `irq_out` one edge later.
- Assert `reset_n` low for 1 cycle while `irq_out` = 1 and edge source 0 is held high:
  - everything clears;
  - pending[0] re-latches after reset release;
  - `irq_out` stays 0 until MASK is rewritten.
